// File: rtl/core_pkg.sv
// Shared definitions for the multicycle core:
// opcodes, FSM states and instruction field positions.
package core_pkg;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SHL   = 4'h5;
  localparam logic [3:0] OP_SHR   = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_LDI   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  function automatic logic alu_op(
    input logic [3:0] op
  );
    return op <= OP_SHR;
  endfunction

  function automatic logic writes_rd(
    input logic [3:0] op
  );
    return (op <= OP_LOAD) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: add/sub/logic/shifts,
// result wraps modulo 2^DATA_W.
module core_alu #(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  import core_pkg::*;

  logic [4:0] sh;
  logic       sh_big;

  assign sh     = b[4:0];
  assign sh_big = int'(sh) >= DATA_W;

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = sh_big ? '0 : a << sh;
      OP_SHR: result = sh_big ? '0 : a >> sh;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_core.sv
// Unpipelined FETCH/DECODE/EXEC/MEM/WB core
// with an internal 16-entry register file.
module multicycle_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);
  import core_pkg::*;

  state_e            state;
  state_e            state_nx;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] disp;
  logic [15:0]       ir;
  logic [3:0]        op;
  logic [3:0]        rd;
  logic [7:0]        imm;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              zero;
  logic              is_mem;
  logic              take_br;
  logic [DATA_W-1:0] rf [NREG];

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign imm = ir[IMM_MSB:IMM_LSB];

  assign is_mem  = (op == OP_LOAD)
                || (op == OP_STORE);
  assign take_br = (op == OP_JMP)
                || (op == OP_JZ && zero);

  // disp8 sign-extended or truncated to PC width
  always_comb begin
    disp = '0;
    for (int i = 0; i < ADDR_W; i++)
      disp[i] = imm[(i < 8) ? i : 7];
  end

  core_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (opa),
    .b      (opb),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_mem:            state_nx = S_MEM;
          (op == OP_HALT):   state_nx = S_HALT;
          default:           state_nx = S_WB;
        endcase
      end
      S_MEM:
        if (dmem_ready) state_nx = S_WB;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    unique case (state)
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_STORE);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign dmem_addr  = opa[ADDR_W-1:0];
  assign dmem_wdata = opb;
  assign imem_addr  = pc;
  assign pc_out     = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= '0;
      ir   <= '0;
      opa  <= '0;
      opb  <= '0;
      res  <= '0;
      zero <= 1'b0;
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else begin
      unique case (state)
        S_DECODE: begin
          ir  <= imem_rdata;
          opa <= rf[imem_rdata[RA_MSB:RA_LSB]];
          opb <= rf[imem_rdata[RB_MSB:RB_LSB]];
        end
        S_EXEC: begin
          res <= (op == OP_LDI) ? DATA_W'(imm)
                                : alu_res;
          if (alu_op(op)) zero <= alu_zero;
        end
        S_MEM:
          if (dmem_ready && op == OP_LOAD)
            res <= dmem_rdata;
        S_WB: begin
          if (writes_rd(op)) rf[rd] <= res;
          pc <= take_br ? pc + disp
                        : pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench: two core instances, one default
// width and one with DATA_W=8, ADDR_W=4.
module tb_multicycle_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: DATA_W=16, ADDR_W=8
  logic [7:0]  ia_addr;
  logic [15:0] ia_rdata;
  logic        a_req, a_we, a_ready, a_halted;
  logic [7:0]  a_addr, a_pc;
  logic [15:0] a_wdata, a_rdata;
  logic [15:0] imem_a [256];
  logic [15:0] dmem_a [256];
  int          delay_a = 0;
  int          cnt_a = 0;

  // instance B: DATA_W=8, ADDR_W=4
  logic [3:0]  ib_addr;
  logic [15:0] ib_rdata;
  logic        b_req, b_we, b_ready, b_halted;
  logic [3:0]  b_addr, b_pc;
  logic [7:0]  b_wdata, b_rdata;
  logic [15:0] imem_b [16];
  logic [7:0]  dmem_b [16];

  multicycle_core u_a (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (ia_addr),
    .imem_rdata (ia_rdata),
    .dmem_req   (a_req),
    .dmem_we    (a_we),
    .dmem_addr  (a_addr),
    .dmem_wdata (a_wdata),
    .dmem_rdata (a_rdata),
    .dmem_ready (a_ready),
    .halted     (a_halted),
    .pc_out     (a_pc)
  );

  multicycle_core #(
    .DATA_W (8),
    .ADDR_W (4)
  ) u_b (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (ib_addr),
    .imem_rdata (ib_rdata),
    .dmem_req   (b_req),
    .dmem_we    (b_we),
    .dmem_addr  (b_addr),
    .dmem_wdata (b_wdata),
    .dmem_rdata (b_rdata),
    .dmem_ready (b_ready),
    .halted     (b_halted),
    .pc_out     (b_pc)
  );

  always @(posedge clk) ia_rdata <= imem_a[ia_addr];
  always @(posedge clk) ib_rdata <= imem_b[ib_addr];

  assign a_rdata = dmem_a[a_addr];
  assign a_ready = a_req && (cnt_a == delay_a);
  assign b_rdata = dmem_b[b_addr];
  assign b_ready = b_req;

  always @(posedge clk) begin
    if (!a_req || a_ready) cnt_a <= 0;
    else                   cnt_a <= cnt_a + 1;
    if (a_req && a_ready && a_we)
      dmem_a[a_addr] <= a_wdata;
    if (b_req && b_ready && b_we)
      dmem_b[b_addr] <= b_wdata;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      imem_a[i] = 16'hC000;
      dmem_a[i] = 16'h0000;
    end
    for (int i = 0; i < 16; i++) begin
      imem_b[i] = 16'hC000;
      dmem_b[i] = 8'h00;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(3);
    checks++;
    if (a_pc !== 8'h00) begin
      errors++;
      $display("FAIL rst_pc got %0h want 0", a_pc);
    end
    checks++;
    if (ia_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_imem got %0h want 0", ia_addr);
    end
    checks++;
    if (a_req !== 1'b0 || a_halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_out got req=%b halt=%b want 0 0",
               a_req, a_halted);
    end
    checks++;
    if (u_a.ir !== 16'h0000 || u_a.rf[7] !== 16'h0) begin
      errors++;
      $display("FAIL rst_state got ir=%h r7=%h want 0 0",
               u_a.ir, u_a.rf[7]);
    end
    checks++;
    if (b_pc !== 4'h0 || b_halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_b got pc=%h halt=%b want 0 0",
               b_pc, b_halted);
    end
  endtask

  task automatic test_add_halt();
    hold_reset();
    imem_a[0] = 16'hB105;
    imem_a[1] = 16'hB203;
    imem_a[2] = 16'h0312;
    imem_a[3] = 16'hF000;
    release_reset();
    step(14);
    checks++;
    if (a_halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_early got %b want 0", a_halted);
    end
    step(2);
    checks++;
    if (a_halted !== 1'b1 || a_pc !== 8'd3) begin
      errors++;
      $display("FAIL halt got halt=%b pc=%0d want 1 3",
               a_halted, a_pc);
    end
    checks++;
    if (u_a.rf[3] !== 16'd8) begin
      errors++;
      $display("FAIL add_r3 got %0h want 8", u_a.rf[3]);
    end
    step(10);
    checks++;
    if (a_pc !== 8'd3 || a_req !== 1'b0
        || a_halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_hold got pc=%0d req=%b want 3 0",
               a_pc, a_req);
    end
  endtask

  task automatic test_jz();
    hold_reset();
    imem_a[0] = 16'hB107;
    imem_a[1] = 16'h1211;
    imem_a[2] = 16'h90FE;
    release_reset();
    step(8);
    checks++;
    if (a_pc !== 8'd2) begin
      errors++;
      $display("FAIL jz_pre got %0d want 2", a_pc);
    end
    step(4);
    checks++;
    if (a_pc !== 8'd0 || u_a.zero !== 1'b1) begin
      errors++;
      $display("FAIL jz_taken got pc=%0d z=%b want 0 1",
               a_pc, u_a.zero);
    end
    hold_reset();
    imem_a[0] = 16'hB108;
    imem_a[1] = 16'hB207;
    imem_a[2] = 16'h1312;
    imem_a[3] = 16'h90FE;
    release_reset();
    step(16);
    checks++;
    if (a_pc !== 8'd4 || u_a.zero !== 1'b0) begin
      errors++;
      $display("FAIL jz_not got pc=%0d z=%b want 4 0",
               a_pc, u_a.zero);
    end
    checks++;
    if (u_a.rf[3] !== 16'd1) begin
      errors++;
      $display("FAIL sub_r3 got %0h want 1", u_a.rf[3]);
    end
  endtask

  task automatic test_mem();
    int st_cyc;
    int ld_cyc;
    st_cyc = 0;
    ld_cyc = 0;
    hold_reset();
    delay_a = 3;
    imem_a[0] = 16'hB104;
    imem_a[1] = 16'hB2BE;
    imem_a[2] = 16'hB308;
    imem_a[3] = 16'h5223;
    imem_a[4] = 16'hB4EF;
    imem_a[5] = 16'h3224;
    imem_a[6] = 16'h8012;
    imem_a[7] = 16'h7510;
    imem_a[8] = 16'hF000;
    release_reset();
    for (int i = 0; i < 300 && !a_halted; i++) begin
      step(1);
      if (a_req) begin
        if (a_we) st_cyc++;
        else      ld_cyc++;
        checks++;
        if (a_addr !== 8'h04
            || (a_we && a_wdata !== 16'hBEEF)) begin
          errors++;
          $display("FAIL mem_hold got a=%h d=%h want 04 beef",
                   a_addr, a_wdata);
        end
      end
    end
    checks++;
    if (a_halted !== 1'b1) begin
      errors++;
      $display("FAIL mem_timeout got halt=%b want 1", a_halted);
    end
    checks++;
    if (st_cyc != 4 || ld_cyc != 4) begin
      errors++;
      $display("FAIL mem_len got st=%0d ld=%0d want 4 4",
               st_cyc, ld_cyc);
    end
    checks++;
    if (dmem_a[4] !== 16'hBEEF) begin
      errors++;
      $display("FAIL store got %h want beef", dmem_a[4]);
    end
    checks++;
    if (u_a.rf[5] !== 16'hBEEF) begin
      errors++;
      $display("FAIL load_r5 got %h want beef", u_a.rf[5]);
    end
    delay_a = 0;
  endtask

  task automatic test_reset_mid_mem();
    bit seen;
    seen = 1'b0;
    hold_reset();
    delay_a = 1000;
    imem_a[0] = 16'hB103;
    imem_a[1] = 16'h7210;
    release_reset();
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      seen = a_req;
    end
    checks++;
    if (!seen || a_addr !== 8'h03) begin
      errors++;
      $display("FAIL mid_req got seen=%b a=%h want 1 03",
               seen, a_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (a_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_drop got %b want 0", a_req);
    end
    checks++;
    if (a_pc !== 8'h00 || u_a.rf[1] !== 16'h0) begin
      errors++;
      $display("FAIL mid_clear got pc=%h r1=%h want 0 0",
               a_pc, u_a.rf[1]);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1);
    checks++;
    if (ia_addr !== 8'h00 || a_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_fetch got a=%h req=%b want 0 0",
               ia_addr, a_req);
    end
    delay_a = 0;
  endtask

  task automatic test_pc_wrap();
    hold_reset();
    imem_b[0]  = 16'hA00E;
    imem_b[14] = 16'hA001;
    imem_b[15] = 16'hC000;
    release_reset();
    step(8);
    checks++;
    if (b_pc !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre got %0d want 15", b_pc);
    end
    step(4);
    checks++;
    if (b_pc !== 4'd0) begin
      errors++;
      $display("FAIL wrap_nop got %0d want 0", b_pc);
    end
    hold_reset();
    imem_b[0]  = 16'hA00E;
    imem_b[14] = 16'hA003;
    imem_b[1]  = 16'hF000;
    release_reset();
    step(4);
    checks++;
    if (b_pc !== 4'd14) begin
      errors++;
      $display("FAIL jmp14 got %0d want 14", b_pc);
    end
    step(4);
    checks++;
    if (b_pc !== 4'd1) begin
      errors++;
      $display("FAIL jmp_wrap got %0d want 1", b_pc);
    end
    step(4);
    checks++;
    if (b_halted !== 1'b1 || b_pc !== 4'd1) begin
      errors++;
      $display("FAIL wrap_halt got h=%b pc=%0d want 1 1",
               b_halted, b_pc);
    end
  endtask

  task automatic test_alu8();
    hold_reset();
    imem_b[0] = 16'hB1FF;
    imem_b[1] = 16'hB201;
    imem_b[2] = 16'h0312;
    imem_b[3] = 16'hB409;
    imem_b[4] = 16'h5514;
    imem_b[5] = 16'hB603;
    imem_b[6] = 16'h5716;
    imem_b[7] = 16'h6816;
    imem_b[8] = 16'h4911;
    imem_b[9] = 16'hF000;
    release_reset();
    step(12);
    checks++;
    if (u_b.rf[3] !== 8'h00 || u_b.zero !== 1'b1) begin
      errors++;
      $display("FAIL add8 got %h z=%b want 00 1",
               u_b.rf[3], u_b.zero);
    end
    step(4);
    checks++;
    if (u_b.zero !== 1'b1) begin
      errors++;
      $display("FAIL ldi_zero got %b want 1", u_b.zero);
    end
    step(12);
    checks++;
    if (u_b.rf[7] !== 8'hF8 || u_b.zero !== 1'b0) begin
      errors++;
      $display("FAIL shl3 got %h z=%b want f8 0",
               u_b.rf[7], u_b.zero);
    end
    step(4);
    checks++;
    if (u_b.rf[8] !== 8'h1F) begin
      errors++;
      $display("FAIL shr3 got %h want 1f", u_b.rf[8]);
    end
    step(4);
    checks++;
    if (u_b.rf[9] !== 8'h00 || u_b.zero !== 1'b1) begin
      errors++;
      $display("FAIL xor got %h z=%b want 00 1",
               u_b.rf[9], u_b.zero);
    end
    step(3);
    checks++;
    if (u_b.rf[5] !== 8'h00 || b_halted !== 1'b1) begin
      errors++;
      $display("FAIL shl9 got %h h=%b want 00 1",
               u_b.rf[5], b_halted);
    end
  endtask

  initial begin
    test_reset();
    test_add_halt();
    test_jz();
    test_mem();
    test_reset_mid_mem();
    test_pc_wrap();
    test_alu8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
